// File: rtl/aespim_pkg.sv
// Shared AES-PIM types and GF(2^8) helpers for the cipher core and its lanes.
package aespim_pkg;
  typedef logic [3:0][3:0][7:0] aes_block_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} cc_state_e;

  // Indexed by round-1; the tail entries are never selected.
  localparam logic [7:0] RCON [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                       8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/aespim_cipher_core_if.sv
// Request/response bundle between a bulk-encrypt client and the cipher core.
interface aespim_cipher_core_if;
  import aespim_pkg::*;
  logic       in_valid_i, in_ready_o, abort_i;
  logic       out_valid_o, out_ready_i, busy_o;
  aes_block_t key_i, data_i, data_o;

  modport master (output in_valid_i, key_i, data_i, abort_i, out_ready_i,
                  input  in_ready_o, out_valid_o, data_o, busy_o);
  modport slave  (input  in_valid_i, key_i, data_i, abort_i, out_ready_i,
                  output in_ready_o, out_valid_o, data_o, busy_o);
endinterface

// File: rtl/aespim_bSbox.sv
// AES S-box (encrypt) / inverse S-box (decrypt) as GF(2^8) inversion plus affine map.
module aespim_bSbox
  import aespim_pkg::*;
(
  input  logic       encrypt_i,
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // x^254 == x^-1 in GF(2^8); zero maps to zero for free.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  logic [7:0] fwd_inv, bwd_aff;
  assign fwd_inv = gf_inv(in_i);
  assign bwd_aff = rotl(in_i, 1) ^ rotl(in_i, 3) ^ rotl(in_i, 6) ^ 8'h05;

  always_comb begin
    if (encrypt_i)
      out_o = fwd_inv ^ rotl(fwd_inv, 1) ^ rotl(fwd_inv, 2) ^ rotl(fwd_inv, 3) ^ rotl(fwd_inv, 4) ^ 8'h63;
    else
      out_o = gf_inv(bwd_aff);
  end
endmodule

// File: rtl/aespim_mixcolumn.sv
// One-column MixColumns; row 0 is the top byte of the 32-bit column.
module aespim_mixcolumn
  import aespim_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

// File: rtl/aespim_cipher_core.sv
// Autonomous AES-128 encryptor: one request in, ten rounds with on-the-fly key
// expansion, COLS_PER_CYCLE state columns per cycle.
module aespim_cipher_core
  import aespim_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  aespim_cipher_core_if.slave bus
);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aespim_cipher_core: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  cc_state_e  st_q, st_d;
  aes_block_t state_q, state_d, rk_q, rk_d, nxt_q, nxt_d, data_q, data_d;
  logic [3:0] round_q, round_d;
  logic [1:0] col_q, col_d;

  // Next round key; word 0 lives in the top 32 bits.
  logic [3:0][31:0] rkw, rkn;
  logic [31:0]      rot_w, sub_w;
  logic [7:0]       rcon;
  assign rkw   = rk_q;
  assign rot_w = {rkw[0][23:0], rkw[0][31:24]};
  assign rcon  = RCON[round_q - 4'd1];

  for (genvar b = 0; b < 4; b++) begin : g_ksb
    aespim_bSbox u_sb (.encrypt_i(1'b1), .in_i(rot_w[8*b +: 8]), .out_o(sub_w[8*b +: 8]));
  end

  assign rkn[3] = rkw[3] ^ sub_w ^ {rcon, 24'h0};
  assign rkn[2] = rkw[2] ^ rkn[3];
  assign rkn[1] = rkw[1] ^ rkn[2];
  assign rkn[0] = rkw[0] ^ rkn[1];

  logic [COLS_PER_CYCLE-1:0][31:0] lane_col;
  logic [COLS_PER_CYCLE-1:0][1:0]  lane_idx;

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    logic [1:0]       c;
    logic [3:0][7:0]  sb_col;
    logic [31:0]      mc_col;
    assign c = col_q + 2'(l);
    for (genvar r = 0; r < 4; r++) begin : g_row
      // ShiftRows: row r of output column c comes from input column c+r.
      logic [1:0] src;
      assign src = c + 2'(r);
      aespim_bSbox u_sb (.encrypt_i(1'b1), .in_i(state_q[2'd3 - src][3-r]), .out_o(sb_col[3-r]));
    end
    aespim_mixcolumn u_mc (.col_i(sb_col), .col_o(mc_col));
    assign lane_col[l] = ((round_q == 4'd10) ? 32'(sb_col) : mc_col) ^ rkn[2'd3 - c];
    assign lane_idx[l] = c;
  end

  aes_block_t merged_blk;

  always_comb begin
    merged_blk = nxt_q;
    for (int l = 0; l < COLS_PER_CYCLE; l++) merged_blk[2'd3 - lane_idx[l]] = lane_col[l];

    st_d    = st_q;
    state_d = state_q;
    rk_d    = rk_q;
    nxt_d   = nxt_q;
    data_d  = data_q;
    round_d = round_q;
    col_d   = col_q;
    if (bus.abort_i) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE: if (bus.in_valid_i) begin
          state_d = bus.data_i ^ bus.key_i;
          rk_d    = bus.key_i;
          round_d = 4'd1;
          col_d   = 2'd0;
          st_d    = ROUND;
        end
        ROUND: begin
          nxt_d = merged_blk;
          if (col_q == LAST_COL) begin
            state_d = merged_blk;
            rk_d    = rkn;
            col_d   = 2'd0;
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
              data_d = merged_blk;
              st_d   = DONE;
            end
          end else begin
            col_d = col_q + 2'(COLS_PER_CYCLE);
          end
        end
        DONE: if (bus.out_ready_i) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      nxt_q   <= '0;
      data_q  <= '0;
      round_q <= '0;
      col_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      nxt_q   <= nxt_d;
      data_q  <= data_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  assign bus.in_ready_o  = (st_q == IDLE);
  assign bus.out_valid_o = (st_q == DONE);
  assign bus.busy_o      = (st_q == ROUND) || (st_q == DONE);
  assign bus.data_o      = data_q;
endmodule

// File: tb/tb_aespim_cipher_core.sv
// Bench for aespim_cipher_core at COLS_PER_CYCLE = 1, 2, 4 against a byte-level AES model.
module tb_aespim_cipher_core;
  import aespim_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   in_valid = '0, abort = '0, out_ready = '0;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] key [3], din [3], dout [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aespim_cipher_core_if ifc ();
    aespim_cipher_core #(.COLS_PER_CYCLE(1 << g)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));
    assign ifc.in_valid_i  = in_valid[g];
    assign ifc.abort_i     = abort[g];
    assign ifc.out_ready_i = out_ready[g];
    assign ifc.key_i       = key[g];
    assign ifc.data_i      = din[g];
    assign in_ready[g]     = ifc.in_ready_o;
    assign out_valid[g]    = ifc.out_valid_o;
    assign busy[g]         = ifc.busy_o;
    assign dout[g]         = ifc.data_o;
  end

  logic [0:255][7:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] m2(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // FIPS-197 Cipher() over a 16-byte array with a precomputed key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0]  s [16], t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sbox_tab[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rn < 10) begin
          s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rn+c][31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_out(input int k, output logic [127:0] ct, output int lat);
    int n = 0;
    ct = '0; lat = -1;
    while (!out_valid[k] && n < 200) begin step(); n++; end
    if (out_valid[k]) begin lat = n; ct = dout[k]; end
  endtask

  // Presents one request, returns ciphertext and cycles from accept edge to out_valid.
  task automatic run_op(input int k, input logic [127:0] kk, input logic [127:0] pt,
                        output logic [127:0] ct, output int lat);
    int n = 0;
    in_valid[k] = 1'b1; key[k] = kk; din[k] = pt;
    while (!in_ready[k] && n < 200) begin step(); n++; end
    step();
    in_valid[k] = 1'b0;
    wait_out(k, ct, lat);
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1; step(); out_ready[k] = 1'b0;
  endtask

  task automatic stream(input int k, input int n);
    logic [127:0] eq [$];
    logic [127:0] kk, pp, e;
    int cyc = 0, sent = 0, recv = 0, last = -1, lat_c = 10 * (4 >> k);
    logic acc, xf;
    out_ready[k] = 1'b1;
    kk = rnd128(); pp = rnd128();
    key[k] = kk; din[k] = pp; in_valid[k] = 1'b1;
    while (recv < n && cyc < n * (lat_c + 2) + 100) begin
      acc = in_valid[k] & in_ready[k];
      xf  = out_valid[k] & out_ready[k];
      if (xf) begin
        e = (eq.size() > 0) ? eq.pop_front() : '1;
        chk($sformatf("stream ct k%0d #%0d", k, recv), dout[k], e);
        recv++;
      end
      if (acc) begin
        if (last >= 0) chk($sformatf("stream gap k%0d", k), 128'(cyc - last), 128'(lat_c + 2));
        last = cyc;
        eq.push_back(aes_ref(kk, pp));
        sent++;
      end
      step(); cyc++;
      if (acc) begin
        if (sent == n) in_valid[k] = 1'b0;
        else begin kk = rnd128(); pp = rnd128(); key[k] = kk; din[k] = pp; end
      end
    end
    if (recv < n) chk($sformatf("stream timeout k%0d", k), 128'(recv), 128'(n));
    in_valid[k] = 1'b0; out_ready[k] = 1'b0;
  endtask

  typedef struct { logic [127:0] key, pt, ct; } vec_t;
  vec_t tbl [3];

  initial begin
    logic [127:0] ct, held, kb, pb;
    int lat, s_cyc;
    tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32};
    tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    for (int k = 0; k < 3; k++) begin key[k] = '0; din[k] = '0; end

    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset flags k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
      chk($sformatf("reset data k%0d", k), dout[k], '0);
    end
    @(negedge clk); rst_n = 1'b1;
    step();

    for (int v = 0; v < 3; v++) chk($sformatf("model vec%0d", v), aes_ref(tbl[v].key, tbl[v].pt), tbl[v].ct);

    // Known-answer vectors and latency at every column width.
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 3; k++) begin
        run_op(k, tbl[v].key, tbl[v].pt, ct, lat);
        chk($sformatf("kat vec%0d k%0d", v, k), ct, tbl[v].ct);
        chk($sformatf("kat lat vec%0d k%0d", v, k), 128'(lat), 128'(10 * (4 >> k)));
        chk($sformatf("done busy k%0d", k), busy[k], 1'b1);
        drain(k);
      end

    // Back-pressure: output held, new requests ignored until IDLE.
    for (int k = 0; k < 3; k++) begin
      run_op(k, tbl[0].key, tbl[0].pt, ct, lat);
      held = ct;
      for (int i = 0; i < 7; i++) begin
        in_valid[k] = (i % 2 == 0); key[k] = rnd128(); din[k] = rnd128();
        step();
        chk($sformatf("bp data k%0d c%0d", k, i), dout[k], held);
        chk($sformatf("bp flags k%0d c%0d", k, i), {out_valid[k], in_ready[k], busy[k]}, 3'b101);
      end
      kb = rnd128(); pb = rnd128();
      in_valid[k] = 1'b1; key[k] = kb; din[k] = pb; out_ready[k] = 1'b1;
      step();
      out_ready[k] = 1'b0;
      chk($sformatf("bp idle flags k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
      chk($sformatf("bp data kept k%0d", k), dout[k], held);
      step();
      in_valid[k] = 1'b0;
      wait_out(k, ct, lat);
      chk($sformatf("bp second ct k%0d", k), ct, aes_ref(kb, pb));
      chk($sformatf("bp second lat k%0d", k), 128'(lat), 128'(10 * (4 >> k)));
      drain(k);
    end

    // Abort mid-round, abort with a simultaneous request, abort in DONE.
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b1; key[k] = rnd128(); din[k] = rnd128();
      step();
      in_valid[k] = 1'b0;
      repeat (4 * (4 >> k)) step();
      abort[k] = 1'b1; step(); abort[k] = 1'b0;
      chk($sformatf("abort flags k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
      step();
      chk($sformatf("abort no valid k%0d", k), out_valid[k], 1'b0);
      run_op(k, tbl[0].key, tbl[0].pt, ct, lat);
      chk($sformatf("post-abort ct k%0d", k), ct, tbl[0].ct);
      chk($sformatf("post-abort lat k%0d", k), 128'(lat), 128'(10 * (4 >> k)));
      abort[k] = 1'b1; step(); abort[k] = 1'b0;
      chk($sformatf("abort done k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
      in_valid[k] = 1'b1; abort[k] = 1'b1; step(); abort[k] = 1'b0; in_valid[k] = 1'b0;
      chk($sformatf("abort blocks accept k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
    end

    // Asynchronous reset mid-round on all three engines at once.
    for (int k = 0; k < 3; k++) begin in_valid[k] = 1'b1; key[k] = rnd128(); din[k] = rnd128(); end
    step();
    in_valid = '0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async rst flags k%0d", k), {out_valid[k], in_ready[k], busy[k]}, 3'b010);
      chk($sformatf("async rst data k%0d", k), dout[k], '0);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      run_op(k, tbl[1].key, tbl[1].pt, ct, lat);
      chk($sformatf("post-rst ct k%0d", k), ct, tbl[1].ct);
      drain(k);
    end

    for (int k = 0; k < 3; k++) stream(k, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
